// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream_mux_rr round-robin / fixed-select stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    localparam int   MAX_CH     = 16;

    // Returns {found, index} of the first valid channel strictly after ptr, wrapping at n_ch.
    function automatic logic [4:0] rr_pick(
        input logic [MAX_CH-1:0] valid,
        input logic [3:0]        ptr,
        input logic [4:0]        n_ch
    );
        logic       found;
        logic [3:0] idx;
        logic [4:0] cand;
        found = 1'b0;
        idx   = 4'd0;
        for (int i = 1; i <= MAX_CH; i++) begin
            cand = 5'(ptr) + 5'(i);
            if (cand >= n_ch) begin
                cand = cand - n_ch;
            end
            if (!found && (5'(i) <= n_ch) && valid[cand[3:0]]) begin
                found = 1'b1;
                idx   = cand[3:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/mux_slice.sv
// One SLICE_W-bit N_CH:1 combinational mux slice of the stream_mux_rr datapath.
module mux_slice #(
    parameter  int N_CH    = 4,
    parameter  int SLICE_W = 2,
    localparam int SEL_W   = $clog2(N_CH)
) (
    input  logic [N_CH*SLICE_W-1:0] data_in,
    input  logic [SEL_W-1:0]        grant,
    output logic [SLICE_W-1:0]      data_out
);

    always_comb begin
        data_out = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (grant == SEL_W'(c)) begin
                data_out = data_in[c*SLICE_W +: SLICE_W];
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed or round-robin packet-locked arbitration.
// Optional out_parity port when STREAM_MUX_RR_PARITY_EN is defined.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int N_CH    = 4,
    parameter  int WIDTH   = 8,
    parameter  int SLICE_W = 2,
    localparam int SEL_W   = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [SEL_W-1:0]      out_ch
`ifdef STREAM_MUX_RR_PARITY_EN
    ,
    output logic                  out_parity
`endif
);

    localparam int N_SLICE = WIDTH / SLICE_W;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   held_q, held_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [SEL_W-1:0]   out_ch_q, out_ch_d;

    logic [SEL_W-1:0]   grant;
    logic               has_grant;
    logic               can_load;
    logic               accept;
    logic [4:0]         rr_res;
    logic [WIDTH-1:0]   mux_data;

    // Grant is derived only from registered state plus current requests.
    always_comb begin
        has_grant = 1'b0;
        grant     = '0;
        rr_res    = rr_pick(MAX_CH'(in_valid), 4'(rr_ptr_q), 5'(N_CH));
        if (state_q == LOCKED) begin
            has_grant = 1'b1;
            grant     = held_q;
        end else if (mode == MODE_FIXED) begin
            if ((32'(sel) < 32'(N_CH)) && in_valid[sel]) begin
                has_grant = 1'b1;
                grant     = sel;
            end
        end else begin
            has_grant = rr_res[4];
            grant     = SEL_W'(rr_res[3:0]);
        end
    end

    assign can_load = !out_valid_q || out_ready;
    assign accept   = !rst && has_grant && can_load && in_valid[grant];
    assign in_ready = (!rst && has_grant && can_load) ? (N_CH'(1) << grant) : '0;

    for (genvar k = 0; k < N_SLICE; k++) begin : g_slice
        logic [N_CH*SLICE_W-1:0] slice_in;
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            assign slice_in[c*SLICE_W +: SLICE_W] = in_data[c*WIDTH + k*SLICE_W +: SLICE_W];
        end
        mux_slice #(
            .N_CH    (N_CH),
            .SLICE_W (SLICE_W)
        ) u_slice (
            .data_in  (slice_in),
            .grant    (grant),
            .data_out (mux_data[k*SLICE_W +: SLICE_W])
        );
    end

    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (in_last[grant]) begin
                state_d  = IDLE;
                rr_ptr_d = grant;
            end else begin
                state_d = LOCKED;
                held_d  = grant;
            end
        end
    end

    // Data registers only move on accept, so they stay stable under backpressure.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_last_d  = in_last[grant];
            out_ch_d    = grant;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            held_q      <= '0;
            rr_ptr_q    <= SEL_W'(N_CH - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

`ifdef STREAM_MUX_RR_PARITY_EN
    logic parity_q, parity_d;

    assign parity_d = accept ? ^mux_data : parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

endmodule
